// File: rtl/wb_regfile.sv
`default_nettype none
//==============================================================================
// Module   : wb_regfile
// Purpose  : MIPS write-back select (ALU / lb-extracted load / PC+8) feeding a
//            2-read 1-write register file with hard-wired zero register.
// Options  : define WB_BYPASS_EN for same-cycle write-through on the read ports.
// Revision : 1.0 - initial release
//==============================================================================
module wb_regfile #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    WB_MemtoReg,
    input  logic          WB_RegWrite,
    input  logic          WB_LbOp,
    input  logic [AW-1:0] WB_Rw,
    input  logic [DW-1:0] WB_ALUOut,
    input  logic [DW-1:0] WB_ReadData,
    input  logic [DW-1:0] WB_PCplus8,
    input  logic [AW-1:0] Ra,
    input  logic [AW-1:0] Rb,
    output logic [DW-1:0] busA,
    output logic [DW-1:0] busB,
    output logic [DW-1:0] WB_WriteData,
    output logic          WB_WriteEn
);

    localparam int NREG = 1 << AW;

    logic [DW-1:0] regs [NREG];
    logic [7:0]    load_byte;
    logic [DW-1:0] load_value;

    // Little-endian lane pick; the low address bits come from the effective address.
    always_comb begin
        load_byte = WB_ReadData[7:0];
        case (WB_ALUOut[1:0])
            2'd0:    load_byte = WB_ReadData[7:0];
            2'd1:    load_byte = WB_ReadData[15:8];
            2'd2:    load_byte = WB_ReadData[23:16];
            default: load_byte = WB_ReadData[31:24];
        endcase
    end

    always_comb begin
        load_value = WB_ReadData;
        if (WB_LbOp) begin
            load_value = {{(DW-8){load_byte[7]}}, load_byte};
        end
    end

    always_comb begin
        WB_WriteData = WB_ALUOut;
        case (WB_MemtoReg)
            2'b01:   WB_WriteData = load_value;
            2'b10:   WB_WriteData = WB_PCplus8;
            default: WB_WriteData = WB_ALUOut;
        endcase
    end

    assign WB_WriteEn = WB_RegWrite && (WB_Rw != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (WB_WriteEn) begin
            regs[WB_Rw] <= WB_WriteData;
        end
    end

`ifdef WB_BYPASS_EN
    always_comb begin
        busA = (Ra == '0) ? '0 : regs[Ra];
        busB = (Rb == '0) ? '0 : regs[Rb];
        if (WB_WriteEn && (Ra == WB_Rw)) begin
            busA = WB_WriteData;
        end
        if (WB_WriteEn && (Rb == WB_Rw)) begin
            busB = WB_WriteData;
        end
    end
`else
    // Without bypass a read of the register being written returns the old value.
    always_comb begin
        busA = (Ra == '0) ? '0 : regs[Ra];
        busB = (Rb == '0) ? '0 : regs[Rb];
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
//==============================================================================
// Module   : tb_wb_regfile
// Purpose  : Directed self-checking bench for wb_regfile (honours WB_BYPASS_EN).
// Revision : 1.0 - initial release
//==============================================================================
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic [1:0]  WB_MemtoReg;
    logic        WB_RegWrite;
    logic        WB_LbOp;
    logic [4:0]  WB_Rw;
    logic [31:0] WB_ALUOut;
    logic [31:0] WB_ReadData;
    logic [31:0] WB_PCplus8;
    logic [4:0]  Ra;
    logic [4:0]  Rb;
    logic [31:0] busA;
    logic [31:0] busB;
    logic [31:0] WB_WriteData;
    logic        WB_WriteEn;

    int n_checks = 0;
    int n_fail   = 0;

    wb_regfile #(.DW(32), .AW(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .WB_MemtoReg  (WB_MemtoReg),
        .WB_RegWrite  (WB_RegWrite),
        .WB_LbOp      (WB_LbOp),
        .WB_Rw        (WB_Rw),
        .WB_ALUOut    (WB_ALUOut),
        .WB_ReadData  (WB_ReadData),
        .WB_PCplus8   (WB_PCplus8),
        .Ra           (Ra),
        .Rb           (Rb),
        .busA         (busA),
        .busB         (busB),
        .WB_WriteData (WB_WriteData),
        .WB_WriteEn   (WB_WriteEn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus: drive a write-back beat on the falling edge.
    task automatic drive(input logic [1:0] mt, input logic we, input logic lb,
                         input logic [4:0] rw, input logic [31:0] alu,
                         input logic [31:0] rd, input logic [31:0] pc);
        @(negedge clk);
        WB_MemtoReg = mt;
        WB_RegWrite = we;
        WB_LbOp     = lb;
        WB_Rw       = rw;
        WB_ALUOut   = alu;
        WB_ReadData = rd;
        WB_PCplus8  = pc;
        #1;
    endtask

    task automatic idle();
        drive(2'b00, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        Ra = 5'd5; Rb = 5'd8;
        #1;
        n_checks++;
        if (busA !== 32'h0) begin n_fail++; $display("FAIL reset_busA: got %h expected %h", busA, 32'h0); end
        n_checks++;
        if (busB !== 32'h0) begin n_fail++; $display("FAIL reset_busB: got %h expected %h", busB, 32'h0); end
        n_checks++;
        if (WB_WriteEn !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b expected %b", WB_WriteEn, 1'b0); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_alu_write();
        Ra = 5'd8;
        drive(2'b00, 1'b1, 1'b0, 5'd8, 32'hDEADBEEF, 32'h0, 32'h0);
        n_checks++;
        if (WB_WriteEn !== 1'b1) begin n_fail++; $display("FAIL alu_wen: got %b expected %b", WB_WriteEn, 1'b1); end
        n_checks++;
        if (WB_WriteData !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_wdata: got %h expected %h", WB_WriteData, 32'hDEADBEEF); end
        idle();
        n_checks++;
        if (busA !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_read8: got %h expected %h", busA, 32'hDEADBEEF); end
    endtask

    task automatic test_lb();
        logic [31:0] exp_wd [5];
        logic [1:0]  lane   [5];
        logic        lbop   [5];
        exp_wd[0] = 32'hFFFFFFF4; lane[0] = 2'd2; lbop[0] = 1'b1;
        exp_wd[1] = 32'h00000012; lane[1] = 2'd3; lbop[1] = 1'b1;
        exp_wd[2] = 32'h00000078; lane[2] = 2'd0; lbop[2] = 1'b1;
        exp_wd[3] = 32'h00000056; lane[3] = 2'd1; lbop[3] = 1'b1;
        exp_wd[4] = 32'h12F45678; lane[4] = 2'd3; lbop[4] = 1'b0;
        Ra = 5'd9;
        for (int i = 0; i < 5; i++) begin
            drive(2'b01, 1'b1, lbop[i], 5'd9, {30'h0400, lane[i]}, 32'h12F45678, 32'h0);
            n_checks++;
            if (WB_WriteData !== exp_wd[i]) begin n_fail++; $display("FAIL lb_wdata[%0d]: got %h expected %h", i, WB_WriteData, exp_wd[i]); end
            idle();
            n_checks++;
            if (busA !== exp_wd[i]) begin n_fail++; $display("FAIL lb_read9[%0d]: got %h expected %h", i, busA, exp_wd[i]); end
        end
    endtask

    task automatic test_jal();
        Ra = 5'd31; Rb = 5'd12;
        drive(2'b10, 1'b1, 1'b0, 5'd31, 32'h77, 32'h99, 32'h00003008);
        n_checks++;
        if (WB_WriteData !== 32'h00003008) begin n_fail++; $display("FAIL jal_wdata: got %h expected %h", WB_WriteData, 32'h00003008); end
        drive(2'b11, 1'b1, 1'b1, 5'd12, 32'h00000055, 32'h99, 32'h00003008);
        n_checks++;
        if (WB_WriteData !== 32'h00000055) begin n_fail++; $display("FAIL mt11_wdata: got %h expected %h", WB_WriteData, 32'h00000055); end
        idle();
        n_checks++;
        if (busA !== 32'h00003008) begin n_fail++; $display("FAIL jal_read31: got %h expected %h", busA, 32'h00003008); end
        n_checks++;
        if (busB !== 32'h00000055) begin n_fail++; $display("FAIL mt11_read12: got %h expected %h", busB, 32'h00000055); end
    endtask

    task automatic test_reg0();
        Ra = 5'd0; Rb = 5'd0;
        drive(2'b00, 1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0);
        n_checks++;
        if (WB_WriteEn !== 1'b0) begin n_fail++; $display("FAIL r0_wen: got %b expected %b", WB_WriteEn, 1'b0); end
        n_checks++;
        if (busA !== 32'h0) begin n_fail++; $display("FAIL r0_before: got %h expected %h", busA, 32'h0); end
        @(posedge clk); #1;
        n_checks++;
        if (busA !== 32'h0) begin n_fail++; $display("FAIL r0_after_a: got %h expected %h", busA, 32'h0); end
        n_checks++;
        if (busB !== 32'h0) begin n_fail++; $display("FAIL r0_after_b: got %h expected %h", busB, 32'h0); end
        idle();
    endtask

    task automatic test_same_cycle();
        logic [31:0] exp_now;
`ifdef WB_BYPASS_EN
        exp_now = 32'hA5A5A5A5;
`else
        exp_now = 32'h00000001;
`endif
        Ra = 5'd10; Rb = 5'd10;
        drive(2'b00, 1'b1, 1'b0, 5'd10, 32'h00000001, 32'h0, 32'h0);
        drive(2'b00, 1'b1, 1'b0, 5'd10, 32'hA5A5A5A5, 32'h0, 32'h0);
        n_checks++;
        if (busA !== exp_now) begin n_fail++; $display("FAIL same_busA: got %h expected %h", busA, exp_now); end
        n_checks++;
        if (busB !== exp_now) begin n_fail++; $display("FAIL same_busB: got %h expected %h", busB, exp_now); end
        idle();
        n_checks++;
        if (busA !== 32'hA5A5A5A5 || busB !== 32'hA5A5A5A5) begin
            n_fail++; $display("FAIL same_after: got %h/%h expected %h", busA, busB, 32'hA5A5A5A5);
        end
    endtask

    task automatic test_async_reset();
        Ra = 5'd5; Rb = 5'd8;
        drive(2'b00, 1'b1, 1'b0, 5'd5, 32'h00001234, 32'h0, 32'h0);
        idle();
        n_checks++;
        if (busA !== 32'h00001234) begin n_fail++; $display("FAIL pre_reset_r5: got %h expected %h", busA, 32'h00001234); end
        // Assert reset between edges; the array must clear without a clock.
        #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if (busA !== 32'h0) begin n_fail++; $display("FAIL async_clr_r5: got %h expected %h", busA, 32'h0); end
        n_checks++;
        if (busB !== 32'h0) begin n_fail++; $display("FAIL async_clr_r8: got %h expected %h", busB, 32'h0); end
        // Write strobe present on an edge while reset is held: register stays zero.
        drive(2'b00, 1'b1, 1'b0, 5'd5, 32'h0000BEEF, 32'h0, 32'h0);
        @(posedge clk); #1;
        Ra = 5'd7;
        #1;
        n_checks++;
        if (busB !== 32'h0) begin n_fail++; $display("FAIL reset_wins: got %h expected %h", busB, 32'h0); end
        // Release mid-cycle; the pending write lands on the next edge.
        Rb = 5'd5;
        #1;
        reset = 1'b0;
        #1;
`ifndef WB_BYPASS_EN
        n_checks++;
        if (busB !== 32'h0) begin n_fail++; $display("FAIL release_no_write: got %h expected %h", busB, 32'h0); end
`endif
        @(posedge clk); #1;
        idle();
        n_checks++;
        if (busB !== 32'h0000BEEF) begin n_fail++; $display("FAIL release_write: got %h expected %h", busB, 32'h0000BEEF); end
    endtask

    initial begin
        reset       = 1'b1;
        WB_MemtoReg = 2'b00;
        WB_RegWrite = 1'b0;
        WB_LbOp     = 1'b0;
        WB_Rw       = 5'd0;
        WB_ALUOut   = 32'h0;
        WB_ReadData = 32'h0;
        WB_PCplus8  = 32'h0;
        Ra          = 5'd0;
        Rb          = 5'd0;
        test_reset();
        test_alu_write();
        test_lb();
        test_jal();
        test_reg0();
        test_same_cycle();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage plus the general-purpose register file of the 5-stage MIPS pipeline.
- Consumes the WB_* outputs of the MEM/WB pipeline register and selects the write-back value: ALU result, load data with byte extraction for lb, or PC+8 for jal.
- Commits that value to a 32x32 register file.
- Serves the two ID-stage read ports and exports the write-back value for EX forwarding.

Parameters:
- DW, 32, data width of registers and buses.
- AW, 5, register address width (2^AW registers).

Ports:
- clk  input  1  pipeline clock; register file writes on rising edge.
- reset  input  1  asynchronous, active-high; clears the whole register file.
- WB_MemtoReg  input  2  write-back source select: 00 ALUOut, 01 memory data, 10 PC+8, 11 treated as 00.
- WB_RegWrite  input  1  register write enable from MEM/WB.
- WB_LbOp  input  1  1 = byte load (lb); applies only when WB_MemtoReg=01.
- WB_Rw  input  5  destination register number.
- WB_ALUOut  input  32  ALU result; for loads, the effective address.
- WB_ReadData  input  32  word read from data memory.
- WB_PCplus8  input  32  return address for jal/jalr.
- Ra  input  5  ID read address A (rs).
- Rb  input  5  ID read address B (rt).
- busA  output  32  register value for Ra.
- busB  output  32  register value for Rb.
- WB_WriteData  output  32  selected write-back value, for forwarding to EX.
- WB_WriteEn  output  1  effective write strobe: WB_RegWrite && (WB_Rw != 0).

Behaviour:
- Reset (asynchronous): all 32 registers become 0 immediately on reset assertion, independent of clk.
  - busA and busB therefore read 0 during reset.
  - WB_WriteData and WB_WriteEn remain combinational functions of the inputs. The upstream register drives zeros during reset, which gives WB_WriteData=0 and WB_WriteEn=0.
- Load data path: the byte lane is selected by WB_ALUOut[1:0], little-endian.
  - Lane 0 = ReadData[7:0], lane 1 = [15:8], lane 2 = [23:16], lane 3 = [31:24].
  - When WB_LbOp=1 the chosen byte is sign-extended to 32 bits.
  - When WB_LbOp=0 the load value is the full ReadData; ALUOut[1:0] is ignored (no alignment check here).
- Write-back mux (combinational, zero latency):
  - 00 or 11 -> WB_ALUOut.
  - 01 -> load value.
  - 10 -> WB_PCplus8.
  - The mux output drives WB_WriteData.
- Write:
  - On the rising clk edge with WB_WriteEn=1, reg[WB_Rw] <= WB_WriteData.
  - A write to register 0 is ignored; reg[0] reads 0 always.
  - Latency: value visible through the array read on the cycle after the edge.
- Read (combinational):
  - busA = (Ra==0) ? 0 : reg[Ra]; busB likewise for Rb.
  - Bypass rule applies when WB_BYPASS_EN is defined (see Optional Feature).
- Simultaneous events:
  - Ra == Rb == WB_Rw: both ports see the same value.
  - reset asserted on a clk edge with WB_WriteEn=1: reset wins and the register stays 0.
  - reset deasserted mid-cycle: the first write occurs at the next rising edge.
- No stall input: the stage commits every cycle. Bubbles arrive as WB_RegWrite=0.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined:
  - Internal write-through bypass for same-cycle reads.
  - When WB_WriteEn=1 and Ra==WB_Rw, busA = WB_WriteData; likewise for busB.
  - ID sees the value being written this cycle, so the forwarding unit needs no WB->ID path.
- Undefined:
  - busA/busB return only stored array contents. A read of WB_Rw in the write cycle returns the old value.
  - The hazard unit must stall one extra cycle, or the ID forwarding mux must select WB_WriteData.

Test Plan:
- Assert reset after writing reg5=0x1234 -> busA with Ra=5 reads 0x00000000 immediately, before any clk edge.
- Write: RegWrite=1, Rw=8, MemtoReg=00, ALUOut=0xDEADBEEF, one edge -> next cycle busA(Ra=8)=0xDEADBEEF, and WB_WriteEn=1 during the write cycle.
- lb sign extension: MemtoReg=01, LbOp=1, ReadData=0x12F45678, ALUOut[1:0]=2, Rw=9 -> WB_WriteData=0xFFFFFFF4, reg9=0xFFFFFFF4. Same with ALUOut[1:0]=3 -> 0x00000012.
- jal: MemtoReg=10, PCplus8=0x00003008, Rw=31 -> reg31=0x00003008. With MemtoReg=11, ALUOut=0x55 -> write data 0x55.
- Register 0: RegWrite=1, Rw=0, ALUOut=0xFFFFFFFF -> WB_WriteEn=0 and busA(Ra=0)=0 before and after the edge.
- Same-cycle read, with Ra=Rb=10, Rw=10, ALUOut=0xA5A5A5A5, reg10 previously 0x1:
  - WB_BYPASS_EN defined: busA=busB=0xA5A5A5A5 in the write cycle.
  - WB_BYPASS_EN undefined: busA=busB=0x00000001 in the write cycle, then 0xA5A5A5A5 after the edge.
